// File: rtl/gcm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : gcm_pkg                                                  |
// | Shared widths and GHASH controller state encoding.                 |
// |   BLOCK_W   : GHASH block width                                    |
// |   LEN_W     : width of each half of the GCM length block           |
// |   BYTECNT_W : AAD / ciphertext byte counter width                  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package gcm_pkg;

    localparam int BLOCK_W   = 128;
    localparam int LEN_W     = 64;
    localparam int BYTECNT_W = 32;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_ACCEPT = 3'd1;
    localparam logic [STATE_W-1:0] S_MUL    = 3'd2;
    localparam logic [STATE_W-1:0] S_GAP    = 3'd3;
    localparam logic [STATE_W-1:0] S_LEN    = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd5;

endpackage : gcm_pkg
`default_nettype wire

// File: rtl/gfmul_v2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : gfmul_v2                                                 |
// | GF(2^128) multiplier in GCM bit order. A new product is started on |
// | the rising edge of (iCtext_valid & iHashkey_valid); oResult_valid  |
// | pulses for one cycle the cycle after the operands are sampled.     |
// | Ports   : iClk, iRst (sync, active-high)                           |
// |           iCtext/iCtext_valid, iHashkey/iHashkey_valid - operands  |
// |           oResult/oResult_valid                        - product   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module gfmul_v2
    import gcm_pkg::*;
(
    input  logic               iClk,
    input  logic               iRst,
    input  logic [BLOCK_W-1:0] iCtext,
    input  logic               iCtext_valid,
    input  logic [BLOCK_W-1:0] iHashkey,
    input  logic               iHashkey_valid,
    output logic [BLOCK_W-1:0] oResult,
    output logic               oResult_valid
);

    logic               r_prev_valid;
    logic [BLOCK_W-1:0] r_result;
    logic               r_result_valid;
    logic               w_start;

    // Bit 127 is the coefficient of x^0; R = 11100001 || 0^120.
    function automatic logic [BLOCK_W-1:0] gf_mul(input logic [BLOCK_W-1:0] a,
                                                  input logic [BLOCK_W-1:0] b);
        logic [BLOCK_W-1:0] z;
        logic [BLOCK_W-1:0] v;
        z = '0;
        v = b;
        for (int i = 0; i < BLOCK_W; i++) begin
            if (a[BLOCK_W-1-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'hE1, 120'h0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    assign w_start = iCtext_valid & iHashkey_valid & ~r_prev_valid;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_prev_valid   <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_prev_valid   <= iCtext_valid & iHashkey_valid;
            r_result_valid <= w_start;
            if (w_start) r_result <= gf_mul(iCtext, iHashkey);
        end
    end

    assign oResult       = r_result;
    assign oResult_valid = r_result_valid;

endmodule : gfmul_v2
`default_nettype wire

// File: rtl/ghash_pad.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ghash_pad                                                |
// | Combinational byte mask: keeps the first i_bytes bytes of the      |
// | block (byte 0 = bits 127:120) and forces the rest to zero.         |
// | Ports   : i_block [127:0] in  - raw block                          |
// |           i_bytes [4:0]   in  - valid byte count 0..16             |
// |           o_block [127:0] out - zero-padded block                  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module ghash_pad
    import gcm_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_block,
    input  logic [4:0]         i_bytes,
    output logic [BLOCK_W-1:0] o_block
);

    for (genvar gi = 0; gi < BLOCK_W/8; gi++) begin : g_byte
        assign o_block[BLOCK_W-1-8*gi -: 8] =
            (i_bytes > 5'(gi)) ? i_block[BLOCK_W-1-8*gi -: 8] : 8'h00;
    end

endmodule : ghash_pad
`default_nettype wire

// File: rtl/ghash_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ghash_ctrl                                               |
// | Sequences gfmul_v2 to compute GHASH over AAD then ciphertext       |
// | blocks received on a valid/ready stream, zero-padding partial      |
// | blocks.                                                            |
// | Ports   : iClk, iRst (sync, active-high)                           |
// |           iStart, iHashkey           - message start, H            |
// |           iBlock*, oBlock_ready       - block stream               |
// |           oMul_*, iMul_result*        - multiplier initiator side  |
// |           oGhash, oGhash_valid        - final hash, 1-cycle pulse  |
// |           oBusy, oErr                 - status, sticky order error |
// | Build   : GHASH_LEN_BLOCK_EN defined appends the GCM length block; |
// |           undefined outputs the raw chained product.               |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module ghash_ctrl
    import gcm_pkg::*;
(
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic [BLOCK_W-1:0] iHashkey,
    input  logic [BLOCK_W-1:0] iBlock,
    input  logic               iBlock_valid,
    input  logic               iBlock_aad,
    input  logic [4:0]         iBlock_bytes,
    input  logic               iBlock_last,
    output logic               oBlock_ready,
    output logic [BLOCK_W-1:0] oMul_ctext,
    output logic               oMul_ctext_valid,
    output logic [BLOCK_W-1:0] oMul_hashkey,
    output logic               oMul_hashkey_valid,
    input  logic [BLOCK_W-1:0] iMul_result,
    input  logic               iMul_result_valid,
    output logic [BLOCK_W-1:0] oGhash,
    output logic               oGhash_valid,
    output logic               oBusy,
    output logic               oErr
);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [BLOCK_W-1:0]   r_y;
    logic [BLOCK_W-1:0]   r_x;
    logic [BLOCK_W-1:0]   r_h;
    logic [BLOCK_W-1:0]   r_ghash;
    logic [BLOCK_W-1:0]   w_padded;
    logic [BYTECNT_W-1:0] r_aad_cnt;
    logic [BYTECNT_W-1:0] r_ct_cnt;
    logic                 r_last;
    logic                 r_seen_ct;
    logic                 r_err;
`ifdef GHASH_LEN_BLOCK_EN
    logic                 r_is_len;
`endif
    logic                 w_block_ready;
    logic                 w_mul_valid;
    logic                 w_ghash_valid;
    logic                 w_empty_last;

    ghash_pad u_pad (
        .i_block (iBlock),
        .i_bytes (iBlock_bytes),
        .o_block (w_padded)
    );

    // An empty final block carries no data: skip straight to finishing.
    assign w_empty_last = (iBlock_bytes == 5'd0) && iBlock_last;

    always_ff @(posedge iClk) begin
        if (iRst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_block_ready = 1'b0;
        w_mul_valid   = 1'b0;
        w_ghash_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iStart) w_state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                w_block_ready = 1'b1;
                if (iBlock_valid) begin
`ifdef GHASH_LEN_BLOCK_EN
                    w_state_nxt = w_empty_last ? S_LEN : S_MUL;
`else
                    w_state_nxt = w_empty_last ? S_DONE : S_MUL;
`endif
                end
            end
            S_MUL: begin
                w_mul_valid = 1'b1;
                if (iMul_result_valid) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                // Valid is low here so the multiplier sees a fresh rising edge.
`ifdef GHASH_LEN_BLOCK_EN
                if (r_is_len)    w_state_nxt = S_DONE;
                else if (r_last) w_state_nxt = S_LEN;
                else             w_state_nxt = S_ACCEPT;
`else
                w_state_nxt = r_last ? S_DONE : S_ACCEPT;
`endif
            end
`ifdef GHASH_LEN_BLOCK_EN
            S_LEN: begin
                w_state_nxt = S_MUL;
            end
`endif
            S_DONE: begin
                w_ghash_valid = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_y       <= '0;
            r_x       <= '0;
            r_h       <= '0;
            r_ghash   <= '0;
            r_aad_cnt <= '0;
            r_ct_cnt  <= '0;
            r_last    <= 1'b0;
            r_seen_ct <= 1'b0;
            r_err     <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
            r_is_len  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_h       <= iHashkey;
                        r_y       <= '0;
                        r_x       <= '0;
                        r_ghash   <= '0;
                        r_aad_cnt <= '0;
                        r_ct_cnt  <= '0;
                        r_last    <= 1'b0;
                        r_seen_ct <= 1'b0;
                        r_err     <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
                        r_is_len  <= 1'b0;
`endif
                    end
                end
                S_ACCEPT: begin
                    if (iBlock_valid) begin
                        r_x    <= w_padded;
                        r_last <= iBlock_last;
                        // Counting an empty block adds zero, so no special case.
                        if (iBlock_aad) begin
                            r_aad_cnt <= r_aad_cnt + BYTECNT_W'(iBlock_bytes);
                            if (r_seen_ct) r_err <= 1'b1;
                        end else begin
                            r_ct_cnt  <= r_ct_cnt + BYTECNT_W'(iBlock_bytes);
                            r_seen_ct <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (iMul_result_valid) r_y <= iMul_result;
                end
`ifdef GHASH_LEN_BLOCK_EN
                S_LEN: begin
                    // Bit lengths: zero-extended byte counters shifted left by 3.
                    r_x      <= {{(LEN_W-BYTECNT_W-3){1'b0}}, r_aad_cnt, 3'b000,
                                 {(LEN_W-BYTECNT_W-3){1'b0}}, r_ct_cnt,  3'b000};
                    r_is_len <= 1'b1;
                end
`endif
                default: begin
                end
            endcase
            // Y is final on entry to DONE; capture it so oGhash holds afterwards.
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_ghash <= r_y;
        end
    end

    assign oBlock_ready       = w_block_ready;
    assign oMul_ctext         = w_mul_valid ? (r_y ^ r_x) : '0;
    assign oMul_ctext_valid   = w_mul_valid;
    assign oMul_hashkey       = r_h;
    assign oMul_hashkey_valid = w_mul_valid;
    assign oGhash             = r_ghash;
    assign oGhash_valid       = w_ghash_valid;
    assign oBusy              = (r_state != S_IDLE);
    assign oErr               = r_err;

endmodule : ghash_ctrl
`default_nettype wire

// File: tb/tb_ghash_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_ghash_ctrl                                            |
// | Self-checking bench for ghash_ctrl driving a real gfmul_v2.        |
// | Expected hashes come from a polynomial-arithmetic GHASH model.     |
// | Build   : honours GHASH_LEN_BLOCK_EN like the design.              |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_ghash_ctrl;

`ifdef GHASH_LEN_BLOCK_EN
    localparam int LEN_MULS = 1;
`else
    localparam int LEN_MULS = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] hashkey = '0;
    logic [127:0] blk = '0;
    logic         blk_valid = 1'b0;
    logic         blk_aad = 1'b0;
    logic [4:0]   blk_bytes = '0;
    logic         blk_last = 1'b0;
    logic         blk_ready;
    logic [127:0] mul_ctext;
    logic         mul_ctext_valid;
    logic [127:0] mul_hashkey;
    logic         mul_hk_valid;
    logic [127:0] mul_result;
    logic         mul_rv;
    logic         inj_rv = 1'b0;
    logic         dut_rv;
    logic [127:0] ghash;
    logic         ghash_valid;
    logic         busy;
    logic         err;

    assign dut_rv = mul_rv | inj_rv;

    always #5 clk = ~clk;

    ghash_ctrl dut (
        .iClk(clk), .iRst(rst), .iStart(start), .iHashkey(hashkey),
        .iBlock(blk), .iBlock_valid(blk_valid), .iBlock_aad(blk_aad),
        .iBlock_bytes(blk_bytes), .iBlock_last(blk_last), .oBlock_ready(blk_ready),
        .oMul_ctext(mul_ctext), .oMul_ctext_valid(mul_ctext_valid),
        .oMul_hashkey(mul_hashkey), .oMul_hashkey_valid(mul_hk_valid),
        .iMul_result(mul_result), .iMul_result_valid(dut_rv),
        .oGhash(ghash), .oGhash_valid(ghash_valid), .oBusy(busy), .oErr(err)
    );

    gfmul_v2 u_mul (
        .iClk(clk), .iRst(rst),
        .iCtext(mul_ctext), .iCtext_valid(mul_ctext_valid),
        .iHashkey(mul_hashkey), .iHashkey_valid(mul_hk_valid),
        .oResult(mul_result), .oResult_valid(mul_rv)
    );

    int n_vec = 0;
    int n_err = 0;

    // Monitor: one entry per multiply (rising operand valid), ghash pulses.
    int           mul_cnt = 0;
    int           gv_cnt = 0;
    logic [127:0] ghash_cap = '0;
    logic [127:0] ctext_log[$];
    logic         prev_cv = 1'b0;
    always @(negedge clk) begin
        if (mul_ctext_valid && !prev_cv) begin
            mul_cnt++;
            ctext_log.push_back(mul_ctext);
        end
        prev_cv = mul_ctext_valid;
        if (ghash_valid) begin
            gv_cnt++;
            ghash_cap = ghash;
        end
    end

    // Current message for the driver and the model.
    logic [127:0] msg_d[$];
    int           msg_n[$];
    bit           msg_a[$];
    int           mul0;
    int           gv0;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // GF(2^128) product as polynomials: reflect, carry-less multiply, reduce
    // by x^128 + x^7 + x^2 + x + 1, reflect back.
    function automatic logic [127:0] gf_mul_ref(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] a, b, r;
        logic [255:0] p;
        for (int i = 0; i < 128; i++) begin
            a[i] = x[127-i];
            b[i] = y[127-i];
        end
        p = '0;
        for (int i = 0; i < 128; i++)
            if (a[i]) p = p ^ ({128'h0, b} << i);
        for (int i = 254; i >= 128; i--)
            if (p[i]) begin
                p[i]     = 1'b0;
                p[i-121] = ~p[i-121];
                p[i-126] = ~p[i-126];
                p[i-127] = ~p[i-127];
                p[i-128] = ~p[i-128];
            end
        for (int i = 0; i < 128; i++) r[i] = p[127-i];
        return r;
    endfunction

    function automatic logic [127:0] pad_ref(input logic [127:0] d, input int n);
        logic [127:0] ones;
        ones = '1;
        return d & ~(ones >> (8 * n));
    endfunction

    function automatic logic [127:0] ghash_ref(input logic [127:0] h);
        logic [127:0] y;
        logic [31:0]  la, lc;
        y = '0; la = '0; lc = '0;
        foreach (msg_d[i]) begin
            if (msg_n[i] != 0) begin
                y = gf_mul_ref(y ^ pad_ref(msg_d[i], msg_n[i]), h);
                if (msg_a[i]) la = la + 32'(msg_n[i]);
                else          lc = lc + 32'(msg_n[i]);
            end
        end
`ifdef GHASH_LEN_BLOCK_EN
        y = gf_mul_ref(y ^ {({32'h0, la} << 3), ({32'h0, lc} << 3)}, h);
`endif
        return y;
    endfunction

    function automatic int muls_ref();
        int m;
        m = LEN_MULS;
        foreach (msg_n[i]) if (msg_n[i] != 0) m++;
        return m;
    endfunction

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy !== 1'b0) begin
            @(negedge clk);
            c++;
            if (c > 400) begin
                n_vec++; n_err++;
                $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, c);
                break;
            end
        end
    endtask

    task automatic start_msg(input logic [127:0] h);
        start = 1'b1; hashkey = h;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, input int n, input bit a, input bit last);
        int c;
        blk = d; blk_bytes = 5'(n); blk_aad = a; blk_last = last; blk_valid = 1'b1;
        c = 0;
        forever begin
            @(negedge clk);
            if (blk_ready) break;
            c++;
            if (c > 400) begin
                n_vec++; n_err++;
                $display("FAIL handshake_timeout: ready=%b, want 1", blk_ready);
                break;
            end
        end
        @(posedge clk); #1;
        blk_valid = 1'b0;
    endtask

    task automatic wait_gv(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (gv_cnt != gv0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_msg(input logic [127:0] h, output bit ok);
        wait_idle();
        ctext_log.delete();
        mul0 = mul_cnt; gv0 = gv_cnt;
        start_msg(h);
        foreach (msg_d[i]) send_block(msg_d[i], msg_n[i], msg_a[i], i == msg_d.size() - 1);
        wait_gv(ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({blk_ready, mul_ctext_valid, mul_hk_valid, ghash_valid, busy, err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: rdy/cv/hv/gv/busy/err got %b want 000000",
                     {blk_ready, mul_ctext_valid, mul_hk_valid, ghash_valid, busy, err});
        end
        n_vec++;
        if ({ghash, mul_hashkey, mul_ctext} !== 384'h0) begin
            n_err++;
            $display("FAIL reset_data: ghash=%h hk=%h ctext=%h want 0", ghash, mul_hashkey, mul_ctext);
        end
    endtask

    task automatic test_vec1();
        bit ok;
        logic [127:0] exp;
`ifdef GHASH_LEN_BLOCK_EN
        exp = 128'hF38CBB1AD69223DCC3457AE5B6B0F885;
`else
        exp = 128'h5E2EC746917062882C85B0685353DEB7;
`endif
        msg_d = '{128'h0388DACE60B6A392F328C2B971B2FE78}; msg_n = '{16}; msg_a = '{1'b0};
        run_msg(128'h66E94BD4EF8A2C3B884CFA59CA342B2E, ok);
        n_vec++;
        if (!ok || ghash_cap !== exp) begin
            n_err++;
            $display("FAIL vec1_ghash: done=%0d got %h want %h", ok, ghash_cap, exp);
        end
        n_vec++;
        if (mul_cnt - mul0 !== 1 + LEN_MULS) begin
            n_err++;
            $display("FAIL vec1_muls: got %0d want %0d", mul_cnt - mul0, 1 + LEN_MULS);
        end
    endtask

    task automatic test_vec2();
        bit ok;
        logic [127:0] h, exp;
        h = 128'h73A23D80121DE2D5A850253FCF43120E;
        msg_d = '{128'hD609B1F056637A0D46DF998D88E52E00, 128'hB2C2846512153524C0895E81FFFFFFFF};
        msg_n = '{16, 12}; msg_a = '{1'b1, 1'b1};
`ifdef GHASH_LEN_BLOCK_EN
        exp = ghash_ref(h);
`else
        exp = 128'hB99ABF6BDBD18B8E148F8030F0686F28;
`endif
        run_msg(h, ok);
        n_vec++;
        if (ctext_log.size() < 2 ||
            (ctext_log[1] ^ 128'hB2C2846512153524C0895E8100000000) !== 128'h9CABBD91899C1413AA7AD629C1DF12CD) begin
            n_err++;
            $display("FAIL vec2_y1: muls=%0d got %h want 9cabbd91899c1413aa7ad629c1df12cd",
                     ctext_log.size(), ctext_log.size() > 1 ? ctext_log[1] ^ 128'hB2C2846512153524C0895E8100000000 : 128'h0);
        end
        n_vec++;
        if (!ok || ghash_cap !== exp) begin
            n_err++;
            $display("FAIL vec2_ghash: done=%0d got %h want %h", ok, ghash_cap, exp);
        end
    endtask

    task automatic test_empty();
        bit ok;
        msg_d = '{rand128()}; msg_n = '{0}; msg_a = '{1'b0};
        run_msg(rand128(), ok);
        n_vec++;
        if (!ok || ghash_cap !== 128'h0) begin
            n_err++;
            $display("FAIL empty_ghash: done=%0d got %h want 0", ok, ghash_cap);
        end
        n_vec++;
        if (mul_cnt - mul0 !== LEN_MULS) begin
            n_err++;
            $display("FAIL empty_muls: got %0d want %0d", mul_cnt - mul0, LEN_MULS);
        end
`ifdef GHASH_LEN_BLOCK_EN
        n_vec++;
        if (ctext_log.size() != 1 || ctext_log[0] !== 128'h0) begin
            n_err++;
            $display("FAIL empty_ctext: n=%0d got %h want 0", ctext_log.size(),
                     ctext_log.size() > 0 ? ctext_log[0] : 128'hx);
        end
`endif
    endtask

    task automatic test_order();
        bit ok;
        logic [127:0] h;
        h = rand128();
        msg_d = '{rand128(), rand128(), rand128(), rand128()};
        msg_n = '{16, 16, 16, 9}; msg_a = '{1'b1, 1'b0, 1'b1, 1'b0};
        wait_idle();
        mul0 = mul_cnt; gv0 = gv_cnt;
        start_msg(h);
        send_block(msg_d[0], msg_n[0], msg_a[0], 1'b0);
        send_block(msg_d[1], msg_n[1], msg_a[1], 1'b0);
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL order_pre: err got %b want 0", err); end
        send_block(msg_d[2], msg_n[2], msg_a[2], 1'b0);
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL order_rise: err got %b want 1", err); end
        send_block(msg_d[3], msg_n[3], msg_a[3], 1'b1);
        wait_gv(ok);
        n_vec++;
        if (!ok || ghash_cap !== ghash_ref(h)) begin
            n_err++;
            $display("FAIL order_ghash: done=%0d got %h want %h", ok, ghash_cap, ghash_ref(h));
        end
        n_vec++;
        if (err !== 1'b1) begin n_err++; $display("FAIL order_sticky: err got %b want 1", err); end
        wait_idle();
        gv0 = gv_cnt;
        start_msg(rand128());
        n_vec++;
        if (err !== 1'b0) begin n_err++; $display("FAIL order_clear: err got %b want 0", err); end
        send_block(rand128(), 0, 1'b0, 1'b1);
        wait_gv(ok);
    endtask

    task automatic test_mid_reset();
        wait_idle();
        gv0 = gv_cnt;
        start_msg(rand128());
        send_block(rand128(), 16, 1'b0, 1'b0);
        @(negedge clk);
        n_vec++;
        if (mul_ctext_valid !== 1'b1) begin
            n_err++; $display("FAIL midrst_in_mul: ctext_valid got %b want 1", mul_ctext_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({blk_ready, mul_ctext_valid, mul_hk_valid, ghash_valid, busy, err} !== 6'b0) begin
            n_err++;
            $display("FAIL midrst_flags: rdy/cv/hv/gv/busy/err got %b want 000000",
                     {blk_ready, mul_ctext_valid, mul_hk_valid, ghash_valid, busy, err});
        end
        n_vec++;
        if ({ghash, mul_hashkey, mul_ctext} !== 384'h0) begin
            n_err++;
            $display("FAIL midrst_data: ghash=%h hk=%h ctext=%h want 0", ghash, mul_hashkey, mul_ctext);
        end
        @(posedge clk); #1 inj_rv = 1'b1;
        @(posedge clk); #1 inj_rv = 1'b0;
        repeat (6) @(negedge clk);
        n_vec++;
        if (gv_cnt !== gv0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_late_result: ghash pulses got %0d busy %b want 0 and 0", gv_cnt - gv0, busy);
        end
    endtask

    task automatic test_hold_valid();
        logic [127:0] h;
        int  hs, ngap, nacc, f1, e1, f2;
        bit  bad, done;
        bit  rdy_h[$];
        bit  cv_h[$];
        h = rand128();
        msg_d = '{rand128(), rand128()}; msg_n = '{16, 16}; msg_a = '{1'b0, 1'b0};
        wait_idle();
        mul0 = mul_cnt; gv0 = gv_cnt;
        start_msg(h);
        blk = msg_d[0]; blk_bytes = 5'd16; blk_aad = 1'b0; blk_last = 1'b0; blk_valid = 1'b1;
        hs = 0; bad = 1'b0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            rdy_h.push_back(blk_ready);
            cv_h.push_back(mul_ctext_valid);
            if (blk_ready && mul_ctext_valid) bad = 1'b1;
            if (gv_cnt != gv0) done = 1'b1;
            if (blk_valid && blk_ready) begin
                hs++;
                @(posedge clk); #1;
                if (hs == 1) begin blk = msg_d[1]; blk_last = 1'b1; end
            end
        end
        blk_valid = 1'b0;
        f1 = -1; e1 = -1; f2 = -1;
        foreach (cv_h[i]) begin
            if (f1 < 0 && cv_h[i]) f1 = i;
            else if (f1 >= 0 && e1 < 0 && !cv_h[i]) e1 = i;
            else if (e1 >= 0 && f2 < 0 && cv_h[i]) f2 = i;
        end
        ngap = -1; nacc = -1;
        if (f2 > 0) begin
            ngap = 0; nacc = 0;
            for (int i = e1; i < f2; i++) begin
                if (!cv_h[i] && !rdy_h[i]) ngap++;
                if (rdy_h[i]) nacc++;
            end
        end
        n_vec++;
        if (hs !== 2) begin n_err++; $display("FAIL hold_handshakes: got %0d want 2", hs); end
        n_vec++;
        if (bad !== 1'b0) begin n_err++; $display("FAIL hold_ready_in_mul: got %b want 0", bad); end
        n_vec++;
        if (ngap !== 1) begin n_err++; $display("FAIL hold_gap_cycles: got %0d want 1", ngap); end
        n_vec++;
        if (nacc !== 1) begin n_err++; $display("FAIL hold_accept_cycles: got %0d want 1", nacc); end
        n_vec++;
        if (!done || ghash_cap !== ghash_ref(h)) begin
            n_err++;
            $display("FAIL hold_ghash: done=%0d got %h want %h", done, ghash_cap, ghash_ref(h));
        end
    endtask

    task automatic test_random();
        bit ok;
        int naad, nct, last_n;
        logic [127:0] h;
        for (int m = 0; m < 20; m++) begin
            h = rand128();
            naad = $urandom_range(0, 3);
            nct  = $urandom_range(0, 3);
            msg_d.delete(); msg_n.delete(); msg_a.delete();
            for (int i = 0; i < naad + nct; i++) begin
                msg_d.push_back(rand128());
                msg_n.push_back($urandom_range(1, 16));
                msg_a.push_back(i < naad);
            end
            last_n = $urandom_range(0, 16);
            if (msg_d.size() == 0 || last_n == 0) begin
                msg_d.push_back(rand128()); msg_n.push_back(0); msg_a.push_back(1'b0);
            end
            run_msg(h, ok);
            n_vec++;
            if (!ok || ghash_cap !== ghash_ref(h)) begin
                n_err++;
                $display("FAIL rand%0d_ghash: done=%0d got %h want %h", m, ok, ghash_cap, ghash_ref(h));
            end
            n_vec++;
            if (mul_cnt - mul0 !== muls_ref()) begin
                n_err++;
                $display("FAIL rand%0d_muls: got %0d want %0d", m, mul_cnt - mul0, muls_ref());
            end
            n_vec++;
            if (err !== 1'b0) begin n_err++; $display("FAIL rand%0d_err: got %b want 0", m, err); end
        end
    endtask

    initial begin
        test_reset();
        test_vec1();
        test_vec2();
        test_empty();
        test_order();
        test_hold_valid();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ghash_ctrl
`default_nettype wire

// File: doc/ghash_ctrl.md
# ghash_ctrl

Sequencing controller that drives the GF(2^128) multiplier (`gfmul_v2`) to compute GHASH over a message of AAD blocks followed by ciphertext blocks. It accepts 128-bit blocks on a valid/ready stream and zero-pads partial blocks. For each block it presents `Y ^ X` with the hash key to the multiplier, then waits for the multiplier's result. It sits between the AES-CTR datapath and the tag generator, and acts as the initiator side of the multiplier's `Ctext`/`Hashkey`/`Result` interface.

## Interface
- No parameters; all widths fixed.
- `iClk` in 1: clock; all logic on rising edge.
- `iRst` in 1: reset, synchronous, active-high.
- `iStart` in 1: begin new message; sampled only in IDLE.
- `iHashkey` in 128: H, latched on accepted `iStart`.
- `iBlock` in 128: data block, bit 127 = first bit/byte of block.
- `iBlock_valid` in 1: block present.
- `iBlock_aad` in 1: 1 = AAD block, 0 = ciphertext block.
- `iBlock_bytes` in 5: valid bytes 0..16, left-aligned; 0 legal only with `iBlock_last`.
- `iBlock_last` in 1: final block of message.
- `oBlock_ready` out 1: block accepted when `iBlock_valid & oBlock_ready`.
- `oMul_ctext` out 128: multiplier operand `Y ^ X`.
- `oMul_ctext_valid` out 1: operand valid.
- `oMul_hashkey` out 128: latched H.
- `oMul_hashkey_valid` out 1: equals `oMul_ctext_valid`.
- `iMul_result` in 128: multiplier product.
- `iMul_result_valid` in 1: product valid.
- `oGhash` out 128: final GHASH value.
- `oGhash_valid` out 1: one-cycle pulse.
- `oBusy` out 1: state != IDLE.
- `oErr` out 1: sticky ordering error, cleared on next accepted `iStart`.

## Operation
- States: IDLE, ACCEPT, MUL, GAP, LEN, DONE.
- **IDLE:** `iStart` latches H, clears Y, lengths and `oErr`, then goes to ACCEPT.
- **ACCEPT:** `oBlock_ready`=1.
  - On handshake, X = `iBlock` with bytes at index ≥ `iBlock_bytes` forced to zero (counting from the MSB).
  - The byte count is added to the AAD or CT 32-bit counter selected by `iBlock_aad`.
  - The last/type flags are registered, then the state goes to MUL.
  - Exception: `iBlock_bytes`=0 with `iBlock_last` absorbs nothing and goes to LEN (or DONE, see Configuration).
- **MUL:** drives `oMul_ctext` = Y ^ X with both valids high, holding them until `iMul_result_valid`. It then sets Y = `iMul_result` and goes to GAP.
- **GAP:** valids low for exactly one cycle, so the multiplier sees a fresh rising valid next time.
  - If the absorbed block was last, go to LEN (or DONE).
  - If the block was the length block, go to DONE.
  - Otherwise go back to ACCEPT.
- **LEN:** X = {AAD_bytes·8 as 64 bits, CT_bytes·8 as 64 bits}, zero-extended counters shifted left 3, then go to MUL.
- **DONE:** `oGhash` = Y, `oGhash_valid`=1 for one cycle, then go to IDLE.
- **Ordering:** an AAD block accepted after any CT block sets `oErr`; the block is still absorbed and counted as AAD.
- **Overflow:** counters wrap modulo 2^32 bytes; no flag.
- **Ignored inputs:** `iStart` outside IDLE is ignored. `iMul_result_valid` outside MUL is ignored.
- **Reset values:** all outputs 0; Y, X, H and counters 0; state IDLE.
- **Mid-operation reset:** abandons any pending multiply. A late `iMul_result_valid` is ignored because the block is then in IDLE.

## Timing
- Accepted block to operand valid: 1 cycle.
- Per block: 1 (ACCEPT) + multiplier latency L + 1 (GAP) cycles.
- Result valid to `oGhash_valid` (last block, length block disabled): 2 cycles. With the length block: L + 4 cycles.
- `oGhash` holds its value until the next `iStart` is accepted.
- `oBlock_ready` is low in every state except ACCEPT. Input blocks must be held until handshake.

## Configuration
- `GHASH_LEN_BLOCK_EN` defined: after the last data block, the LEN state appends the length block, giving standard GCM GHASH.
- `GHASH_LEN_BLOCK_EN` undefined:
  - The LEN state is not built.
  - The last block goes directly to DONE, so `oGhash` is the raw chained product.
  - An empty last block outputs the current Y.

## Structure
- Shared package `gcm_pkg`: state encoding, `BLOCK_W`=128, `LEN_W`=64, `BYTECNT_W`=32.
- One sub-module, `ghash_pad`: combinational byte mask that zeroes the trailing `16 - bytes` bytes.
- The FSM, counters and registers live in `ghash_ctrl`.
- The bench instantiates the real `gfmul_v2` behind the multiplier ports.

## Test plan
1. H=66E94BD4EF8A2C3B884CFA59CA342B2E, one CT block 0388DACE60B6A392F328C2B971B2FE78 (16 bytes, last).
   - With `GHASH_LEN_BLOCK_EN`: `oGhash`=F38CBB1AD69223DCC3457AE5B6B0F885.
   - Without it: 5E2EC746917062882C85B0685353DEB7.
2. H=73A23D80121DE2D5A850253FCF43120E, AAD D609B1F056637A0D46DF998D88E52E00 (16 bytes), then AAD B2C2846512153524C0895E81FFFFFFFF (12 bytes, last), macro off.
   - Y after block 1 = 9CABBD91899C1413AA7AD629C1DF12CD.
   - `oGhash`=B99ABF6BDBD18B8E148F8030F0686F28, which proves the trailing FF bytes were masked.
3. Empty message: `iStart`, then bytes=0 with last, macro on.
   - `oGhash`=0.
   - Exactly one multiply is issued, with `oMul_ctext`=0.
4. AAD block, CT block, AAD block.
   - `oErr` rises on the third handshake and stays high.
   - The next `iStart` clears it.
5. Assert `iRst` while in MUL.
   - The next cycle: state IDLE, all outputs 0.
   - A late `iMul_result_valid` pulse produces no `oGhash_valid`.
6. `iBlock_valid` held high during MUL/GAP.
   - `oBlock_ready`=0 and no extra handshake.
   - `oMul_ctext_valid` drops low for exactly one cycle between blocks.
